demux_rr_dispatch: RTL and testbench
====================================

Name: demux_rr_dispatch

Overview:
- Sequencing controller for the 4-way, 4-bit demux datapath.
- Accepts a single valid/ready input stream and steers each word to exactly one of four output channels.
- Target selection is round-robin or software-fixed.
- Holds one word in a registered buffer until the selected channel accepts it; non-selected outputs are driven to zero.

Parameters:
W, 4, data width of input and each output channel
CNT_W, 8, width of the transfer counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_data  input  W  input word
in_valid  input  1  input word present
in_ready  output  1  dispatcher can accept in_data this cycle
mode  input  1  0 = round-robin, 1 = fixed select
sel_fixed  input  2  target channel when mode=1
out_data0  output  W  channel 0 data
out_data1  output  W  channel 1 data
out_data2  output  W  channel 2 data
out_data3  output  W  channel 3 data
out_valid  output  4  one-hot valid, bit i = channel i
out_ready  input  4  per-channel ready, bit i = channel i
cur_sel  output  2  target of the buffered word (rr_ptr when IDLE)
xfer_cnt  output  CNT_W  completed output transfers, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst_n low at posedge):
  - state=IDLE; buf=0; target=0; rr_ptr=0; xfer_cnt=0.
  - While rst_n is low, in_ready=0, out_valid=0 and all out_dataN=0.
  - Reset mid-HOLD discards the buffered word; no transfer is counted.
- State machine, two states:
  - IDLE: buffer empty.
  - HOLD: buffer full, waiting on the target channel.
- Target selection at capture: tsel = mode ? sel_fixed : rr_ptr.
  - target is latched at capture.
  - Changes to mode or sel_fixed during HOLD do not retarget the buffered word.
- IDLE:
  - in_ready=1; out_valid=0.
  - in_valid=1 at posedge: buf<=in_data, target<=tsel, go HOLD.
- HOLD outputs:
  - out_valid = one-hot(target).
  - out_data[target] = buf; the other three out_dataN = 0.
- HOLD transfer, when out_ready[target]=1 at posedge:
  - Transfer completes; xfer_cnt<=xfer_cnt+1, wrapping all-ones to 0.
  - If mode=0: rr_ptr<=rr_ptr+1 modulo 4 (3 wraps to 0).
  - If mode=1: rr_ptr is unchanged.
- HOLD, out_ready[target]=0: hold all state; out_valid and out_data stay stable until accepted, with no drop or retarget.
- out_ready bits of non-target channels are ignored.
- in_ready in HOLD = out_ready[target] (combinational pass-through refill).
  - Transfer plus in_valid in the same cycle: buf<=in_data, stay in HOLD.
  - The new target uses the post-increment pointer: mode=0 gives rr_ptr+1 mod 4; mode=1 gives sel_fixed.
  - Transfer without in_valid: go IDLE.
- Throughput: 1 word/cycle when all channels are ready.
  - Latency from input acceptance to out_valid is 1 cycle, registered.
- No combinational path from in_valid or in_data to any output.
  - The only combinational path is out_ready to in_ready.
- cur_sel = target in HOLD, rr_ptr in IDLE.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> in_ready=0, out_valid=4'b0000, xfer_cnt=0. Release -> in_ready=1, cur_sel=0.
- Round-robin streaming: mode=0, out_ready=4'b1111, words 4'hA,4'hB,4'hC,4'hD,4'hE back-to-back -> out_valid 0001,0010,0100,1000,0001 on consecutive cycles; out_data of the selected channel = A..E in order, others 0; xfer_cnt=5.
- Backpressure: mode=0, rr_ptr=2, out_ready=4'b1011, send 4'h7 -> out_valid=0100 held with out_data2=7 and in_ready=0 for 3 cycles. Raise out_ready[2] -> transfer completes, rr_ptr=3.
- Fixed mode and retarget immunity: mode=1, sel_fixed=1, send 4'h5 with out_ready=0. Change sel_fixed to 3 while holding -> out_valid stays 0010. Set out_ready=4'b0010 -> transfer completes, rr_ptr unchanged. Next word goes to channel 3.
- Reset mid-HOLD: word 4'h9 buffered to channel 0, out_ready=0; assert rst_n=0 one cycle -> out_valid=0, xfer_cnt=0, rr_ptr=0, word lost.
- Counter wrap: CNT_W=8, 256 transfers -> xfer_cnt returns to 0; rr_ptr=0 (256 mod 4).

Source files
------------

// File: rtl/demux_rr_dispatch.sv
// Round-robin / fixed-target dispatcher: one input valid/ready stream steered to
// one of four output channels through a single registered holding buffer.
module demux_rr_dispatch #(
   parameter int W     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [W-1:0]     in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             mode,
   input  logic [1:0]       sel_fixed,
   output logic [W-1:0]     out_data0,
   output logic [W-1:0]     out_data1,
   output logic [W-1:0]     out_data2,
   output logic [W-1:0]     out_data3,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [1:0]       cur_sel,
   output logic [CNT_W-1:0] xfer_cnt
);

   // state | meaning
   // IDLE  | buffer empty, ready for a new word
   // HOLD  | buffer full, presenting word to its latched target channel
   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [W-1:0]     hold_buf;
   logic [1:0]       target;
   logic [1:0]       rr_ptr;
   logic [1:0]       rr_nxt;
   logic [1:0]       tsel;
   logic             xfer;
   logic             can_take;
   logic             accept;

   assign xfer     = (state == HOLD) && out_ready[target];
   assign can_take = (state == IDLE) || xfer;
   assign accept   = in_valid && can_take;

   // A refill in the same cycle as a transfer targets the post-increment pointer.
   assign rr_nxt = (xfer && !mode) ? rr_ptr + 2'd1 : rr_ptr;
   assign tsel   = mode ? sel_fixed : rr_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (xfer && !in_valid) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_buf <= '0;
         target   <= 2'd0;
         rr_ptr   <= 2'd0;
         xfer_cnt <= '0;
      end else begin
         if (accept) begin
            hold_buf <= in_data;
            target   <= tsel;
         end
         if (xfer) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
         end
         rr_ptr <= rr_nxt;
      end
   end

   // Outputs are forced quiet while reset is held, regardless of register contents.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 4'b0000;
      out_data0 = '0;
      out_data1 = '0;
      out_data2 = '0;
      out_data3 = '0;
      if (rst_n) begin
         in_ready = can_take;
         if (state == HOLD) begin
            out_valid[target] = 1'b1;
            case (target)
               2'd0:    out_data0 = hold_buf;
               2'd1:    out_data1 = hold_buf;
               2'd2:    out_data2 = hold_buf;
               default: out_data3 = hold_buf;
            endcase
         end
      end
   end

   assign cur_sel = (state == HOLD) ? target : rr_ptr;

endmodule

// File: tb/tb_demux_rr_dispatch.sv
// Scoreboard bench for demux_rr_dispatch: directed words with hand-computed
// target channels are queued at acceptance and checked when each transfer occurs.
module tb_demux_rr_dispatch;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       mode;
   logic [1:0] sel_fixed;
   logic [3:0] out_data0, out_data1, out_data2, out_data3;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic [1:0] cur_sel;
   logic [7:0] xfer_cnt;

   int checks = 0;
   int errors = 0;
   logic [5:0] exp_q[$];

   always #5 clk = ~clk;

   demux_rr_dispatch #(.W(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mode(mode), .sel_fixed(sel_fixed),
      .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2),
      .out_data3(out_data3), .out_valid(out_valid), .out_ready(out_ready),
      .cur_sel(cur_sel), .xfer_cnt(xfer_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the expected word whenever a transfer is presented and accepted.
   always @(negedge clk) begin
      logic [3:0] d[4];
      logic [5:0] e;
      logic [3:0] oh;
      d[0] = out_data0; d[1] = out_data1; d[2] = out_data2; d[3] = out_data3;
      if (rst_n === 1'b1 && (out_valid & out_ready) != 4'b0000) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_xfer", {28'd0, out_valid}, 32'd0);
         end else begin
            e  = exp_q.pop_front();
            oh = 4'b0001 << e[5:4];
            chk("xfer_channel", {28'd0, out_valid}, {28'd0, oh});
            for (int i = 0; i < 4; i++) begin
               if (i == int'(e[5:4])) chk("xfer_data", {28'd0, d[i]}, {28'd0, e[3:0]});
               else                   chk("idle_chan_zero", {28'd0, d[i]}, 32'd0);
            end
         end
      end
   end

   task automatic send(input logic [3:0] d, input logic [1:0] ch, input bit push);
      bit done = 0;
      in_data  = d;
      in_valid = 1'b1;
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge clk);
         if (in_ready) begin
            if (push) exp_q.push_back({ch, d});
            done = 1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) chk("send_timeout", 32'd1, 32'd0);
   endtask

   task automatic drain();
      bit done = 0;
      for (int n = 0; n < 100 && !done; n++) begin
         @(posedge clk); #2;
         if (exp_q.size() == 0) done = 1;
      end
      if (!done) chk("drain_timeout", exp_q.size(), 32'd0);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] rr_words[5];
      rr_words = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
      rst_n = 1'b0; in_data = '0; in_valid = 1'b0; mode = 1'b0;
      sel_fixed = 2'd0; out_ready = 4'b0000;

      // Reset then idle
      cycles(2);
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
      chk("rst_out_data", {16'd0, out_data0, out_data1, out_data2, out_data3}, 32'd0);
      chk("rst_xfer_cnt", {24'd0, xfer_cnt}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
      chk("idle_cur_sel", {30'd0, cur_sel}, 32'd0);
      chk("idle_out_valid", {28'd0, out_valid}, 32'd0);
      @(posedge clk); #1;

      // Round-robin streaming A..E back to back: channels 0,1,2,3,0
      out_ready = 4'b1111;
      for (int i = 0; i < 5; i++) send(rr_words[i], 2'(i % 4), 1'b1);
      drain();
      chk("rr_xfer_cnt", {24'd0, xfer_cnt}, 32'd5);
      chk("rr_ptr_after5", {30'd0, cur_sel}, 32'd1);

      // Advance pointer to 2, then backpressure on channel 2
      send(4'h3, 2'd1, 1'b1);
      drain();
      chk("rr_ptr_is2", {30'd0, cur_sel}, 32'd2);
      out_ready = 4'b1011;
      send(4'h7, 2'd2, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_out_valid", {28'd0, out_valid}, 32'h4);
         chk("bp_out_data2", {28'd0, out_data2}, 32'h7);
         chk("bp_others_zero", {20'd0, out_data0, out_data1, out_data3}, 32'd0);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 4'b1111;
      drain();
      chk("bp_rr_ptr", {30'd0, cur_sel}, 32'd3);
      chk("bp_xfer_cnt", {24'd0, xfer_cnt}, 32'd7);

      // Fixed mode and retarget immunity
      mode = 1'b1; sel_fixed = 2'd1; out_ready = 4'b0000;
      send(4'h5, 2'd1, 1'b1);
      sel_fixed = 2'd3;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("fix_out_valid", {28'd0, out_valid}, 32'h2);
         chk("fix_cur_sel", {30'd0, cur_sel}, 32'd1);
         @(posedge clk); #1;
      end
      out_ready = 4'b0010;
      drain();
      chk("fix_rr_unchanged", {30'd0, cur_sel}, 32'd3);
      out_ready = 4'b1111;
      send(4'h6, 2'd3, 1'b1);
      drain();
      chk("fix_xfer_cnt", {24'd0, xfer_cnt}, 32'd9);

      // Reset mid-HOLD: pointer to 0, buffer 9 for channel 0, then reset
      mode = 1'b0;
      send(4'h1, 2'd3, 1'b1);
      drain();
      chk("pre_rst_rr", {30'd0, cur_sel}, 32'd0);
      out_ready = 4'b0000;
      send(4'h9, 2'd0, 1'b0);
      @(negedge clk);
      chk("hold9_valid", {28'd0, out_valid}, 32'h1);
      chk("hold9_data", {28'd0, out_data0}, 32'h9);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_valid", {28'd0, out_valid}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_xfer_cnt", {24'd0, xfer_cnt}, 32'd0);
      chk("midrst_rr", {30'd0, cur_sel}, 32'd0);
      chk("midrst_idle_valid", {28'd0, out_valid}, 32'd0);
      @(posedge clk); #1;

      // Counter wrap: 255 then one more transfer
      out_ready = 4'b1111;
      for (int i = 0; i < 255; i++) send(4'(i), 2'(i % 4), 1'b1);
      drain();
      chk("cnt_255", {24'd0, xfer_cnt}, 32'd255);
      chk("rr_after255", {30'd0, cur_sel}, 32'd3);
      send(4'hF, 2'd3, 1'b1);
      drain();
      chk("cnt_wrap", {24'd0, xfer_cnt}, 32'd0);
      chk("rr_after256", {30'd0, cur_sel}, 32'd0);

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
